// File: rtl/sram_ctrl_pkg.sv
// Shared state encoding, widths and byte-enable defines for the asynchronous SRAM controller.
// The byte-select defines are guarded so an existing platform header can supply them first.
`ifndef SRAM_BSEL_BUS
`define SRAM_BSEL_BUS 3:0
`endif
`ifndef BE
`define BE 1'b0
`endif

package sram_ctrl_pkg;

   localparam int SRAM_ADDR_W = 20;
   localparam int SRAM_DATA_W = 32;

   // Byte-enable bus with every lane deasserted, derived from the asserted level.
   localparam logic [`SRAM_BSEL_BUS] BE_NONE = {4{~`BE}};

   typedef enum logic [1:0] {
      IDLE,
      SETUP,
      STROBE,
      HOLD
   } state_t;

endpackage

// File: rtl/sram_io_buf.sv
// Bidirectional pad buffer for the SRAM data bus: drives dout onto the pad when oe is set,
// and always returns the resolved pad value on din.
module sram_io_buf #(
   parameter int WIDTH = 32
) (
   input  logic             oe,
   input  logic [WIDTH-1:0] dout,
   output logic [WIDTH-1:0] din,
   inout  wire  [WIDTH-1:0] pad
);

   assign pad = oe ? dout : {WIDTH{1'bz}};
   assign din = pad;

endmodule

// File: rtl/sram_ctrl.sv
// Single-port asynchronous SRAM controller for the MEM stage: one access per request,
// sequenced as SETUP -> STROBE (WAIT_CYCLES clocks) -> HOLD, with the pipeline stalled meanwhile.
module sram_ctrl
   import sram_ctrl_pkg::*;
#(
   parameter int WAIT_CYCLES = 1
) (
   input  logic                    CLK,
   input  logic                    RST,
   input  logic                    REQ_I,
   input  logic                    WE_I,
   input  logic [31:0]             ADDR_I,
   input  logic [31:0]             WDATA_I,
   input  logic [`SRAM_BSEL_BUS]   BE_I,
   output logic                    STALL_O,
   output logic                    RVALID_O,
   output logic [31:0]             RDATA_O,
   output logic [SRAM_ADDR_W-1:0]  SRAM_ADDR_O,
   inout  wire  [SRAM_DATA_W-1:0]  SRAM_DATA_IO,
   output logic [`SRAM_BSEL_BUS]   SRAM_BE_N_O,
   output logic                    SRAM_CE_N_O,
   output logic                    SRAM_OE_N_O,
   output logic                    SRAM_WE_N_O
);

   localparam logic [3:0] CNT_LOAD = 4'(WAIT_CYCLES - 1);

   state_t                   r_state;
   state_t                   w_nextState;
   logic [3:0]               r_cnt;
   logic                     r_we;
   logic [SRAM_ADDR_W-1:0]   r_addr;
   logic [SRAM_DATA_W-1:0]   r_wdata;
   logic [`SRAM_BSEL_BUS]    r_beN;
   logic [SRAM_DATA_W-1:0]   r_rdata;
   logic                     w_busOe;
   logic [SRAM_DATA_W-1:0]   w_busIn;
   logic                     w_unusedAddr;

   // Byte-offset and upper address bits have no meaning for a 1M-word SRAM.
   assign w_unusedAddr = ^{ADDR_I[31:22], ADDR_I[1:0]};

   always_ff @(posedge CLK) begin
      if (RST) r_state <= IDLE;
      else     r_state <= w_nextState;
   end

   always_comb begin
      w_nextState = r_state;
      STALL_O     = 1'b0;
      RVALID_O    = 1'b0;
      SRAM_CE_N_O = 1'b1;
      SRAM_OE_N_O = 1'b1;
      SRAM_WE_N_O = 1'b1;
      SRAM_BE_N_O = BE_NONE;
      w_busOe     = 1'b0;
      case (r_state)
         IDLE: begin
            STALL_O = REQ_I;
            if (REQ_I) w_nextState = SETUP;
         end
         SETUP: begin
            STALL_O     = 1'b1;
            SRAM_CE_N_O = 1'b0;
            SRAM_BE_N_O = r_beN;
            w_busOe     = r_we;
            w_nextState = STROBE;
         end
         STROBE: begin
            STALL_O     = 1'b1;
            SRAM_CE_N_O = 1'b0;
            SRAM_BE_N_O = r_beN;
            SRAM_OE_N_O = r_we;
            SRAM_WE_N_O = ~r_we;
            w_busOe     = r_we;
            if (r_cnt == 4'd0) w_nextState = HOLD;
         end
         HOLD: begin
            SRAM_CE_N_O = 1'b0;
            SRAM_BE_N_O = r_beN;
            RVALID_O    = ~r_we;
            w_busOe     = r_we;
            w_nextState = IDLE;
         end
         default: w_nextState = IDLE;
      endcase
   end

   // Request fields are captured only on IDLE acceptance; load data is sampled on the last strobe edge.
   always_ff @(posedge CLK) begin
      if (RST) begin
         r_cnt   <= 4'd0;
         r_we    <= 1'b0;
         r_addr  <= '0;
         r_wdata <= '0;
         r_beN   <= BE_NONE;
         r_rdata <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (REQ_I) begin
                  r_we    <= WE_I;
                  r_addr  <= ADDR_I[21:2];
                  r_wdata <= WDATA_I;
                  r_beN   <= BE_I;
               end
            end
            SETUP: r_cnt <= CNT_LOAD;
            STROBE: begin
               if (r_cnt == 4'd0) begin
                  if (!r_we) r_rdata <= w_busIn;
               end else begin
                  r_cnt <= r_cnt - 4'd1;
               end
            end
            default: ;
         endcase
      end
   end

   assign SRAM_ADDR_O = r_addr;
   assign RDATA_O     = r_rdata;

   sram_io_buf #(
      .WIDTH (SRAM_DATA_W)
   ) u_ioBuf (
      .oe   (w_busOe),
      .dout (r_wdata),
      .din  (w_busIn),
      .pad  (SRAM_DATA_IO)
   );

endmodule

// File: tb/tb_sram_ctrl.sv
// Directed bench for sram_ctrl: one instance with WAIT_CYCLES=1 and one with WAIT_CYCLES=3,
// each with a simple SRAM model returning a fixed word whenever its output enable is low.
module tb_sram_ctrl;

   logic        CLK;
   logic        RST;
   logic        reqI;
   logic        weI;
   logic [31:0] addrI;
   logic [31:0] wdataI;
   logic [3:0]  beI;

   logic        stall1, rvalid1, ceN1, oeN1, weN1;
   logic [31:0] rdata1;
   logic [19:0] sramAddr1;
   logic [3:0]  beN1;
   wire  [31:0] bus1;

   logic        stall3, rvalid3, ceN3, oeN3, weN3;
   logic [31:0] rdata3;
   logic [19:0] sramAddr3;
   logic [3:0]  beN3;
   wire  [31:0] bus3;

   logic [31:0] mem1;
   logic [31:0] mem3;

   int errors;
   int checks;

   assign bus1 = (!oeN1) ? mem1 : 32'hzzzz_zzzz;
   assign bus3 = (!oeN3) ? mem3 : 32'hzzzz_zzzz;

   sram_ctrl #(.WAIT_CYCLES(1)) dut1 (
      .CLK(CLK), .RST(RST), .REQ_I(reqI), .WE_I(weI), .ADDR_I(addrI), .WDATA_I(wdataI), .BE_I(beI),
      .STALL_O(stall1), .RVALID_O(rvalid1), .RDATA_O(rdata1), .SRAM_ADDR_O(sramAddr1),
      .SRAM_DATA_IO(bus1), .SRAM_BE_N_O(beN1), .SRAM_CE_N_O(ceN1), .SRAM_OE_N_O(oeN1), .SRAM_WE_N_O(weN1)
   );

   sram_ctrl #(.WAIT_CYCLES(3)) dut3 (
      .CLK(CLK), .RST(RST), .REQ_I(reqI), .WE_I(weI), .ADDR_I(addrI), .WDATA_I(wdataI), .BE_I(beI),
      .STALL_O(stall3), .RVALID_O(rvalid3), .RDATA_O(rdata3), .SRAM_ADDR_O(sramAddr3),
      .SRAM_DATA_IO(bus3), .SRAM_BE_N_O(beN3), .SRAM_CE_N_O(ceN3), .SRAM_OE_N_O(oeN3), .SRAM_WE_N_O(weN3)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // Read and write strobes must never overlap on either instance.
   always @(negedge CLK) begin
      checks++;
      assert ((weN1 | oeN1) && (weN3 | oeN3)) else begin
         errors++;
         $display("[TB] FAIL strobe_overlap at %0t: dut1 we_n=%b oe_n=%b dut3 we_n=%b oe_n=%b",
                  $time, weN1, oeN1, weN3, oeN3);
      end
   end

   typedef struct {
      string       name;
      logic        dut3Sel;
      logic        req;
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  be;
      logic        expStall;
      logic        expRvalid;
      logic        expCeN;
      logic        expOeN;
      logic        expWeN;
      logic [3:0]  expBeN;
      logic [19:0] expAddr;
      int          busMode;
      logic [31:0] expBus;
      logic        chkRdata;
      logic [31:0] expRdata;
   } vec_t;

   vec_t vecs[$];

   task automatic addVec(input string name, input logic dut3Sel, input logic req, input logic we,
                         input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] be,
                         input logic expStall, input logic expRvalid, input logic expCeN,
                         input logic expOeN, input logic expWeN, input logic [3:0] expBeN,
                         input logic [19:0] expAddr, input int busMode, input logic [31:0] expBus,
                         input logic chkRdata, input logic [31:0] expRdata);
      vec_t v;
      v.name = name; v.dut3Sel = dut3Sel; v.req = req; v.we = we; v.addr = addr; v.wdata = wdata;
      v.be = be; v.expStall = expStall; v.expRvalid = expRvalid; v.expCeN = expCeN;
      v.expOeN = expOeN; v.expWeN = expWeN; v.expBeN = expBeN; v.expAddr = expAddr;
      v.busMode = busMode; v.expBus = expBus; v.chkRdata = chkRdata; v.expRdata = expRdata;
      vecs.push_back(v);
   endtask

   // Drive one cycle of inputs just after the falling edge, then settle before sampling.
   task automatic applyStimulus(input logic req, input logic we, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic [3:0] be);
      @(negedge CLK);
      reqI   = req;
      weI    = we;
      addrI  = addr;
      wdataI = wdata;
      beI    = be;
      #1;
   endtask

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
      end
   endtask

   task automatic checkNotDriven(input string name, input logic [31:0] act, input logic [31:0] forbid);
      checks++;
      if (act === forbid) begin
         errors++;
         $display("[TB] FAIL %s at %0t: bus shows %h, expected it released", name, $time, act);
      end
   endtask

   logic [31:0] tStall, tRvalid, tCeN, tOeN, tWeN, tBeN, tAddr, tBus, tRdata;

   initial begin
      errors = 0;
      checks = 0;
      mem1   = 32'hDEAD_BEEF;
      mem3   = 32'hCAFE_F00D;
      RST    = 1'b1;
      reqI   = 1'b0; weI = 1'b0; addrI = '0; wdataI = '0; beI = 4'hF;

      // Load on the 1-wait instance; the 3-wait instance loads too and finishes by ld_idle3.
      addVec("ld_accept", 0, 1, 0, 32'h0000_1004, 32'h0, 4'h0, 1, 0, 1, 1, 1, 4'hF, 20'h00000, 0, 0, 1, 32'h0);
      addVec("ld_setup",  0, 0, 0, 32'h0000_1004, 32'h0, 4'h0, 1, 0, 0, 1, 1, 4'h0, 20'h00401, 0, 0, 1, 32'h0);
      addVec("ld_strobe", 0, 0, 0, 32'h0000_1004, 32'h0, 4'h0, 1, 0, 0, 0, 1, 4'h0, 20'h00401, 0, 0, 1, 32'h0);
      addVec("ld_hold",   0, 0, 0, 32'h0000_1004, 32'h0, 4'h0, 0, 1, 0, 1, 1, 4'h0, 20'h00401, 0, 0, 1, 32'hDEAD_BEEF);
      addVec("ld_idle1",  0, 0, 0, 32'h0000_1004, 32'h0, 4'h0, 0, 0, 1, 1, 1, 4'hF, 20'h00401, 0, 0, 1, 32'hDEAD_BEEF);
      addVec("ld_idle2",  0, 0, 0, 32'h0000_1004, 32'h0, 4'h0, 0, 0, 1, 1, 1, 4'hF, 20'h00401, 0, 0, 1, 32'hDEAD_BEEF);
      addVec("ld_idle3",  0, 0, 0, 32'h0000_1004, 32'h0, 4'h0, 0, 0, 1, 1, 1, 4'hF, 20'h00401, 0, 0, 1, 32'hDEAD_BEEF);
      // Store on the 3-wait instance, with address/data/enables scrambled after acceptance.
      addVec("st_accept", 1, 1, 1, 32'h0000_0008, 32'h1234_5678, 4'b1100, 1, 0, 1, 1, 1, 4'hF,    20'h00401, 2, 32'h1234_5678, 1, 32'hCAFE_F00D);
      addVec("st_setup",  1, 0, 0, 32'hFFFF_FFFC, 32'h0,         4'b0000, 1, 0, 0, 1, 1, 4'b1100, 20'h00002, 1, 32'h1234_5678, 1, 32'hCAFE_F00D);
      addVec("st_strb1",  1, 0, 0, 32'hFFFF_FFFC, 32'h0,         4'b0000, 1, 0, 0, 1, 0, 4'b1100, 20'h00002, 1, 32'h1234_5678, 0, 32'h0);
      addVec("st_strb2",  1, 0, 0, 32'hFFFF_FFFC, 32'h0,         4'b0000, 1, 0, 0, 1, 0, 4'b1100, 20'h00002, 1, 32'h1234_5678, 0, 32'h0);
      addVec("st_strb3",  1, 0, 0, 32'hFFFF_FFFC, 32'h0,         4'b0000, 1, 0, 0, 1, 0, 4'b1100, 20'h00002, 1, 32'h1234_5678, 0, 32'h0);
      addVec("st_hold",   1, 0, 0, 32'hFFFF_FFFC, 32'h0,         4'b0000, 0, 0, 0, 1, 1, 4'b1100, 20'h00002, 1, 32'h1234_5678, 0, 32'h0);
      addVec("st_idle",   1, 0, 0, 32'hFFFF_FFFC, 32'h0,         4'b0000, 0, 0, 1, 1, 1, 4'hF,    20'h00002, 2, 32'h1234_5678, 1, 32'hCAFE_F00D);

      repeat (2) @(negedge CLK);
      applyStimulus(0, 0, 32'h0, 32'h0, 4'hF);
      RST = 1'b0;
      #1;
      checkOutput("rst_stall1",  {31'h0, stall1},  32'h0);
      checkOutput("rst_rvalid1", {31'h0, rvalid1}, 32'h0);
      checkOutput("rst_strobes1", {29'h0, ceN1, oeN1, weN1}, 32'h7);
      checkOutput("rst_ben1",    {28'h0, beN1},    32'hF);
      checkOutput("rst_addr1",   {12'h0, sramAddr1}, 32'h0);
      checkOutput("rst_rdata1",  rdata1,           32'h0);
      checkOutput("rst_strobes3", {29'h0, ceN3, oeN3, weN3}, 32'h7);
      checkOutput("rst_rdata3",  rdata3,           32'h0);

      foreach (vecs[i]) begin
         applyStimulus(vecs[i].req, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].be);
         if (vecs[i].dut3Sel) begin
            tStall = {31'h0, stall3}; tRvalid = {31'h0, rvalid3}; tCeN = {31'h0, ceN3};
            tOeN = {31'h0, oeN3}; tWeN = {31'h0, weN3}; tBeN = {28'h0, beN3};
            tAddr = {12'h0, sramAddr3}; tBus = bus3; tRdata = rdata3;
         end else begin
            tStall = {31'h0, stall1}; tRvalid = {31'h0, rvalid1}; tCeN = {31'h0, ceN1};
            tOeN = {31'h0, oeN1}; tWeN = {31'h0, weN1}; tBeN = {28'h0, beN1};
            tAddr = {12'h0, sramAddr1}; tBus = bus1; tRdata = rdata1;
         end
         checkOutput({vecs[i].name, "_stall"},  tStall,  {31'h0, vecs[i].expStall});
         checkOutput({vecs[i].name, "_rvalid"}, tRvalid, {31'h0, vecs[i].expRvalid});
         checkOutput({vecs[i].name, "_ce_n"},   tCeN,    {31'h0, vecs[i].expCeN});
         checkOutput({vecs[i].name, "_oe_n"},   tOeN,    {31'h0, vecs[i].expOeN});
         checkOutput({vecs[i].name, "_we_n"},   tWeN,    {31'h0, vecs[i].expWeN});
         checkOutput({vecs[i].name, "_be_n"},   tBeN,    {28'h0, vecs[i].expBeN});
         checkOutput({vecs[i].name, "_addr"},   tAddr,   {12'h0, vecs[i].expAddr});
         if (vecs[i].busMode == 1) checkOutput({vecs[i].name, "_bus"}, tBus, vecs[i].expBus);
         if (vecs[i].busMode == 2) checkNotDriven({vecs[i].name, "_bus_released"}, tBus, vecs[i].expBus);
         if (vecs[i].chkRdata) checkOutput({vecs[i].name, "_rdata"}, tRdata, vecs[i].expRdata);
      end

      // REQ_I held through HOLD on the 1-wait instance: one access, then a second accepted 4 cycles later.
      begin
         logic [8:0]  expStallSeq;
         logic [8:0]  expRvalidSeq;
         logic [8:0]  expCeNSeq;
         logic [19:0] expAddrSeq [9];
         expStallSeq  = 9'b001110111;
         expRvalidSeq = 9'b010001000;
         expCeNSeq    = 9'b100010001;
         expAddrSeq   = '{20'h2, 20'h8, 20'h8, 20'h8, 20'h8, 20'h10, 20'h10, 20'h10, 20'h10};
         for (int k = 0; k < 9; k++) begin
            applyStimulus((k < 8) ? 1'b1 : 1'b0, 1'b0, (k == 0) ? 32'h0000_0020 : 32'h0000_0040,
                          32'h0, 4'h0);
            checkOutput($sformatf("b2b_stall_c%0d", k),  {31'h0, stall1},  {31'h0, expStallSeq[k]});
            checkOutput($sformatf("b2b_rvalid_c%0d", k), {31'h0, rvalid1}, {31'h0, expRvalidSeq[k]});
            checkOutput($sformatf("b2b_ce_n_c%0d", k),   {31'h0, ceN1},    {31'h0, expCeNSeq[k]});
            checkOutput($sformatf("b2b_addr_c%0d", k),   {12'h0, sramAddr1}, {12'h0, expAddrSeq[k]});
         end
      end

      repeat (4) applyStimulus(0, 0, 32'h0, 32'h0, 4'hF);

      // Reset pulsed during the strobe of a load aborts it without a data-valid beat.
      applyStimulus(1, 0, 32'h0000_1004, 32'h0, 4'h0);
      checkOutput("abort_accept_stall", {31'h0, stall1}, 32'h1);
      applyStimulus(0, 0, 32'h0, 32'h0, 4'hF);
      checkOutput("abort_setup_ce_n", {31'h0, ceN1}, 32'h0);
      applyStimulus(0, 0, 32'h0, 32'h0, 4'hF);
      checkOutput("abort_strobe_oe_n", {31'h0, oeN1}, 32'h0);
      RST = 1'b1;
      @(negedge CLK);
      RST = 1'b0;
      #1;
      checkOutput("abort_strobes",  {29'h0, ceN1, oeN1, weN1}, 32'h7);
      checkOutput("abort_stall",    {31'h0, stall1},  32'h0);
      checkOutput("abort_rvalid",   {31'h0, rvalid1}, 32'h0);
      checkOutput("abort_be_n",     {28'h0, beN1},    32'hF);
      checkOutput("abort_addr",     {12'h0, sramAddr1}, 32'h0);
      checkOutput("abort_rdata",    rdata1,           32'h0);
      checkNotDriven("abort_bus1_released", bus1, 32'hDEAD_BEEF);
      checkNotDriven("abort_bus3_released", bus3, 32'h1234_5678);
      for (int k = 0; k < 3; k++) begin
         applyStimulus(0, 0, 32'h0, 32'h0, 4'hF);
         checkOutput($sformatf("abort_no_rvalid_c%0d", k), {31'h0, rvalid1}, 32'h0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
